// File: rtl/ecc_rx_pkg.sv
// Shared definitions for the SECDED receive decoder.
//   CW_WIDTH / DATA_WIDTH / SYN_WIDTH : codeword, payload and syndrome widths
//   DATA_POS                          : codeword bit index carrying data[i]
//   entry_t                           : output buffer entry {data, sb_err, db_err}
package ecc_rx_pkg;

  localparam int CW_WIDTH   = 39;
  localparam int DATA_WIDTH = 32;
  localparam int SYN_WIDTH  = 6;

  // Data bits fill every non-power-of-two position from 3 upward.
  localparam logic [SYN_WIDTH-1:0] DATA_POS [DATA_WIDTH] = '{
    6'd3,  6'd5,  6'd6,  6'd7,  6'd9,  6'd10, 6'd11, 6'd12,
    6'd13, 6'd14, 6'd15, 6'd17, 6'd18, 6'd19, 6'd20, 6'd21,
    6'd22, 6'd23, 6'd24, 6'd25, 6'd26, 6'd27, 6'd28, 6'd29,
    6'd30, 6'd31, 6'd33, 6'd34, 6'd35, 6'd36, 6'd37, 6'd38
  };

  typedef struct packed {
    logic [DATA_WIDTH-1:0] data;
    logic                  sb_err;
    logic                  db_err;
  } entry_t;

endpackage

// File: rtl/ecc_rx_fifo.sv
// Output buffer for decoded words.
//   clk_i, reset_n : clock, async active-low reset
//   push, push_entry : write side (no backpressure; words are dropped when full)
//   pop_rdy          : consumer accept; pops when head_vld is also high
//   head_vld, head_entry : head of buffer, entry forced to zero when empty
//   overflow         : sticky, set when a push was dropped
// DEPTH must be a power of two, at least 2.
module ecc_rx_fifo
  import ecc_rx_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic   clk_i,
  input  logic   reset_n,
  input  logic   push,
  input  entry_t push_entry,
  input  logic   pop_rdy,
  output logic   head_vld,
  output entry_t head_entry,
  output logic   overflow
);

  localparam int AW = $clog2(DEPTH);

  if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("ecc_rx_fifo: DEPTH must be a power of two >= 2");
  end

  entry_t          mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [AW:0]     count;
  logic            full;
  logic            pop;
  logic            push_ok;

  assign head_vld   = (count != '0);
  assign full       = (count == (AW+1)'(DEPTH));
  assign pop        = head_vld && pop_rdy;
  // A pop in the same cycle frees the slot the full-case push writes into.
  assign push_ok    = push && (!full || pop);
  assign head_entry = head_vld ? mem[rd_ptr] : '0;

  always_ff @(posedge clk_i) begin
    if (push_ok) begin
      mem[wr_ptr] <= push_entry;
    end
  end

  always_ff @(posedge clk_i or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (push && !push_ok) overflow <= 1'b1;
    end
  end

endmodule

// File: rtl/ecc_rx_decode.sv
// SECDED (39,32) receive decoder with a small output buffer.
//   clk_i, reset_n         : clock, async active-low reset
//   data_in_vld, data_in   : one-cycle codeword pulses, no backpressure
//   data_out_vld/rdy       : valid/ready output handshake
//   data_out, sb_err, db_err : corrected word and its error flags
//   overflow               : sticky, a word was dropped on a full buffer
//   cnt_clr, ce_cnt, ue_cnt : error counters and their synchronous clear
// Optional feature macro: ECC_RX_ERR_CNT_EN enables the saturating error
// counters; without it ce_cnt/ue_cnt are tied to zero and cnt_clr is ignored.
// Pipeline: stage 1 registers syndrome/parity/codeword, stage 2 corrects
// combinationally and pushes into the buffer, giving a two-cycle latency.
module ecc_rx_decode
  import ecc_rx_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk_i,
  input  logic                  reset_n,
  input  logic                  data_in_vld,
  input  logic [CW_WIDTH-1:0]   data_in,
  output logic                  data_out_vld,
  input  logic                  data_out_rdy,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  sb_err,
  output logic                  db_err,
  output logic                  overflow,
  input  logic                  cnt_clr,
  output logic [15:0]           ce_cnt,
  output logic [15:0]           ue_cnt
);

  logic [SYN_WIDTH-1:0]  syn;
  logic                  par;
  logic                  s1_vld;
  logic [SYN_WIDTH-1:0]  s1_syn;
  logic                  s1_par;
  logic [CW_WIDTH-1:0]   s1_cw;
  logic                  flip;
  logic                  dbl;
  entry_t                push_entry;
  entry_t                head_entry;
  logic                  unused_par_bits;

  always_comb begin
    syn = '0;
    for (int i = 1; i < CW_WIDTH; i++) begin
      if (data_in[i]) syn = syn ^ i[SYN_WIDTH-1:0];
    end
    par = ^data_in;
  end

  always_ff @(posedge clk_i or negedge reset_n) begin
    if (!reset_n) begin
      s1_vld <= 1'b0;
      s1_syn <= '0;
      s1_par <= 1'b0;
      s1_cw  <= '0;
    end else begin
      s1_vld <= data_in_vld;
      if (data_in_vld) begin
        s1_syn <= syn;
        s1_par <= par;
        s1_cw  <= data_in;
      end
    end
  end

  // Odd parity means a single flip; a syndrome beyond the codeword cannot
  // come from one bit, so that case is reported as uncorrectable.
  always_comb begin
    flip = s1_par && (s1_syn <= 6'd38);
    dbl  = (!s1_par && (s1_syn != '0)) || (s1_par && (s1_syn > 6'd38));
    push_entry = '0;
    for (int i = 0; i < DATA_WIDTH; i++) begin
      push_entry.data[i] = s1_cw[DATA_POS[i]] ^ (flip && (s1_syn == DATA_POS[i]));
    end
    push_entry.sb_err = flip;
    push_entry.db_err = dbl;
  end

  // Check-bit positions carry no payload once the syndrome is formed.
  assign unused_par_bits = ^{s1_cw[0], s1_cw[1], s1_cw[2], s1_cw[4],
                             s1_cw[8], s1_cw[16], s1_cw[32]};

  ecc_rx_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i      (clk_i),
    .reset_n    (reset_n),
    .push       (s1_vld),
    .push_entry (push_entry),
    .pop_rdy    (data_out_rdy),
    .head_vld   (data_out_vld),
    .head_entry (head_entry),
    .overflow   (overflow)
  );

  assign data_out = head_entry.data;
  assign sb_err   = head_entry.sb_err;
  assign db_err   = head_entry.db_err;

`ifdef ECC_RX_ERR_CNT_EN
  // Counts every classified word, including one dropped on overflow.
  always_ff @(posedge clk_i or negedge reset_n) begin
    if (!reset_n) begin
      ce_cnt <= '0;
      ue_cnt <= '0;
    end else if (cnt_clr) begin
      ce_cnt <= '0;
      ue_cnt <= '0;
    end else if (s1_vld) begin
      if (flip && (ce_cnt != 16'hFFFF)) ce_cnt <= ce_cnt + 1'b1;
      if (dbl  && (ue_cnt != 16'hFFFF)) ue_cnt <= ue_cnt + 1'b1;
    end
  end
`else
  logic unused_cnt_clr;
  assign unused_cnt_clr = cnt_clr;
  assign ce_cnt = '0;
  assign ue_cnt = '0;
`endif

endmodule

// File: doc/ecc_rx_decode.md
ECC_RX_DECODE -- requirements
Module: ecc_rx_decode

Interface
REQ-001 Parameter FIFO_DEPTH, default 4, output buffer entries; SHALL be a power of two, at least 2.
REQ-002 Port clk_i  in  1  sole clock, the DMUX output-domain clock.
REQ-003 Port reset_n  in  1  reset, asynchronous assert, active-low.
REQ-004 Port data_in_vld  in  1  one-cycle pulse per word from DMUX data_out_vld; there is no backpressure.
REQ-005 Port data_in  in  39  SECDED codeword from DMUX data_out.
REQ-006 Port data_out_vld  out  1  buffer head valid.
REQ-007 Port data_out_rdy  in  1  consumer accept; a transfer occurs when data_out_vld and data_out_rdy are both high.
REQ-008 Port data_out  out  32  corrected data word.
REQ-009 Port sb_err / db_err  out  1 each  error flags of the head word, qualified by data_out_vld.
REQ-010 Port overflow  out  1  sticky flag: a word was dropped.
REQ-011 Port cnt_clr  in  1  synchronous clear of the error counters.
REQ-012 Port ce_cnt / ue_cnt  out  16 each  corrected and uncorrectable error counts.

Function
REQ-013 Codeword layout SHALL be as follows:
- bit 0: overall parity.
- bits 1, 2, 4, 8, 16, 32: Hamming parity.
- remaining bits 3..38 ascending: data[0]..data[31].
REQ-014 Stage 1 SHALL register the 6-bit syndrome s (XOR of the indices of all set bits 1..38), the overall parity p (XOR of all 39 bits) and the codeword, on data_in_vld.
REQ-015 Stage 2 SHALL classify and correct the word as follows:
- s=0, p=0: clean.
- p=1: single error; flip bit s when 1 ≤ s ≤ 38, sb_err=1.
- p=0, s≠0: double error; data passed uncorrected, db_err=1.
- p=1 with s>38: treated as a double error.
REQ-016 Stage 2 output SHALL be pushed into a FIFO_DEPTH-entry FIFO holding {data, sb_err, db_err}.
REQ-017 Latency: a word with data_in_vld high in cycle N SHALL appear as data_out_vld in cycle N+2 when the FIFO is empty; there is no bypass path.
REQ-018 Back-to-back data_in_vld every cycle SHALL be sustained with no bubbles.
REQ-019 Push when full SHALL be accepted if a pop occurs in the same cycle; otherwise the word SHALL be dropped and overflow set.
REQ-020 overflow SHALL stay set until reset.
REQ-021 Simultaneous push and pop on an empty FIFO is impossible by latency; push and pop at any occupancy SHALL keep the count unchanged.
REQ-022 FIFO pointers SHALL wrap modulo FIFO_DEPTH; the count SHALL be held as log2(FIFO_DEPTH)+1 bits.
REQ-023 data_out, sb_err and db_err SHALL be stable while data_out_vld=1 and data_out_rdy=0.

Reset
REQ-024 reset_n low SHALL asynchronously clear all of the following:
- pipeline valids and FIFO pointers/count;
- data_out_vld, sb_err, db_err and overflow to 0;
- data_out to 32'h0;
- ce_cnt and ue_cnt to 16'h0.
REQ-025 Words in flight at reset SHALL be discarded; the first data_in_vld after release SHALL behave per REQ-017.

Configuration
REQ-026 With ECC_RX_ERR_CNT_EN defined, ce_cnt/ue_cnt SHALL behave as follows:
- increment on each pushed sb_err/db_err word, including a word dropped on overflow;
- saturate at 16'hFFFF;
- clear on cnt_clr, with cnt_clr taking priority over increment.
REQ-027 Without ECC_RX_ERR_CNT_EN, the counter logic SHALL be absent, ce_cnt/ue_cnt SHALL be tied to 16'h0, and cnt_clr SHALL be ignored.

Structure
REQ-028 Shared package ecc_rx_pkg SHALL hold the following:
- CW_WIDTH=39, DATA_WIDTH=32, SYN_WIDTH=6;
- the data-bit-to-codeword position table;
- the entry typedef {data, sb_err, db_err}.
REQ-029 The FIFO SHALL be a sub-module named ecc_rx_fifo; syndrome and correction logic SHALL live in the top.

Verification
REQ-030 Bench SHALL cover: all-zero codeword pulsed at cycle N -> data_out_vld at N+2, data_out=32'h0, sb_err=0, db_err=0.
REQ-031 Bench SHALL cover: codeword with only bit 3 set -> data_out=32'h0, sb_err=1, ce_cnt=1 (macro on).
REQ-032 Bench SHALL cover: bits 3 and 5 set -> data_out=32'h3, db_err=1, ue_cnt=1 (macro on).
REQ-033 Bench SHALL cover: data_out_rdy=0 with 5 pulses -> 4 entries held, overflow=1 after the 5th; raising rdy drains exactly 4 words in order.
REQ-034 Bench SHALL cover: full FIFO with rdy=1 and a push in the same cycle -> both accepted, overflow stays 0.
REQ-035 Bench SHALL cover: reset_n pulsed low with 2 words buffered -> data_out_vld=0 and overflow=0 immediately; the next pulse emerges 2 cycles later.
